// File: rtl/zap_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// zap_fetch_sequencer
//
// Instruction fetch sequencer feeding the pipeline FIFO stage. It keeps the
// program counter, issues one read at a time on a req/ack bus, and writes each
// returned instruction into the FIFO stage tagged with its PC and abort status.
// Redirects reload the PC. A response that belongs to a request made before a
// redirect is dropped.
//
// Optional build macro:
//   ZAP_FETCH_PERF_EN - adds the saturating o_fetch_cnt / o_discard_cnt outputs.
//
// State table:
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   ST_IDLE    | no read outstanding; issue when halt/full/valid/redirect allow
//   ST_REQ     | read outstanding, response still wanted
//   ST_DISCARD | read outstanding, redirected meanwhile; response gets dropped
// -----------------------------------------------------------------------------
module zap_fetch_sequencer #(
    parameter int          WDT      = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_redirect,
    input  logic [31:0]     i_redirect_pc,
    input  logic            i_halt,
    input  logic            i_fifo_full,
    output logic            o_rd_req,
    output logic [31:0]     o_rd_addr,
    input  logic            i_rd_ack,
    input  logic [WDT-1:0]  i_rd_data,
    input  logic            i_rd_err,
    output logic            o_valid,
    output logic [WDT-1:0]  o_instr,
    output logic [31:0]     o_pc,
    output logic            o_abort
`ifdef ZAP_FETCH_PERF_EN
    ,
    output logic [31:0]     o_fetch_cnt,
    output logic [31:0]     o_discard_cnt
`endif
);

    localparam logic [31:0] PC_INC = 32'(WDT / 8);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [31:0]     pc, pc_nxt;
    logic            rd_req_nxt;
    logic [31:0]     rd_addr_nxt;
    logic            valid_nxt;
    logic [WDT-1:0]  instr_nxt;
    logic [31:0]     pc_out_nxt;
    logic            abort_nxt;

    // State, PC and all outputs are registered here; nothing combinational
    // reaches a port.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            o_rd_req  <= 1'b0;
            o_rd_addr <= 32'h0;
            o_valid   <= 1'b0;
            o_instr   <= '0;
            o_pc      <= 32'h0;
            o_abort   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            o_rd_req  <= rd_req_nxt;
            o_rd_addr <= rd_addr_nxt;
            o_valid   <= valid_nxt;
            o_instr   <= instr_nxt;
            o_pc      <= pc_out_nxt;
            o_abort   <= abort_nxt;
        end
    end

    // Next-state, PC and output decode. o_valid defaults low so it is always
    // a single-cycle pulse, and a redirect never lets a write through.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        rd_req_nxt  = o_rd_req;
        rd_addr_nxt = o_rd_addr;
        valid_nxt   = 1'b0;
        instr_nxt   = o_instr;
        pc_out_nxt  = o_pc;
        abort_nxt   = o_abort;

        case (state)
            ST_IDLE: begin
                // Waiting for o_valid to drop means i_fifo_full already covers
                // the last write, so one outstanding read can never overflow.
                if (i_redirect) begin
                    pc_nxt = i_redirect_pc;
                end else if (!i_halt && !i_fifo_full && !o_valid) begin
                    rd_req_nxt  = 1'b1;
                    rd_addr_nxt = pc;
                    state_nxt   = ST_REQ;
                end
            end

            ST_REQ: begin
                if (i_rd_ack) begin
                    rd_req_nxt = 1'b0;
                    state_nxt  = ST_IDLE;
                    if (i_redirect) begin
                        pc_nxt = i_redirect_pc;
                    end else begin
                        valid_nxt  = 1'b1;
                        instr_nxt  = i_rd_err ? '0 : i_rd_data;
                        pc_out_nxt = o_rd_addr;
                        abort_nxt  = i_rd_err;
                        pc_nxt     = pc + PC_INC;
                    end
                end else if (i_redirect) begin
                    // Bus rule: request and address stay put until the ack.
                    pc_nxt    = i_redirect_pc;
                    state_nxt = ST_DISCARD;
                end
            end

            ST_DISCARD: begin
                if (i_redirect) begin
                    pc_nxt = i_redirect_pc;
                end
                if (i_rd_ack) begin
                    rd_req_nxt = 1'b0;
                    state_nxt  = ST_IDLE;
                end
            end

            default: begin
                state_nxt  = ST_IDLE;
                rd_req_nxt = 1'b0;
            end
        endcase
    end

`ifdef ZAP_FETCH_PERF_EN
    logic fetch_evt;
    logic discard_evt;

    assign fetch_evt   = valid_nxt;
    assign discard_evt = i_rd_ack &&
                         ((state == ST_DISCARD) || ((state == ST_REQ) && i_redirect));

    // Saturating counters of delivered and dropped responses.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_fetch_cnt   <= 32'h0;
            o_discard_cnt <= 32'h0;
        end else begin
            if (fetch_evt && (o_fetch_cnt != 32'hFFFF_FFFF)) begin
                o_fetch_cnt <= o_fetch_cnt + 32'h1;
            end
            if (discard_evt && (o_discard_cnt != 32'hFFFF_FFFF)) begin
                o_discard_cnt <= o_discard_cnt + 32'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_zap_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_zap_fetch_sequencer - directed bench for zap_fetch_sequencer
// (RESET_PC = 0x100, WDT = 32). Inputs are driven 1 ns after the rising edge
// and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_zap_fetch_sequencer;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_halt;
    logic        i_fifo_full;
    logic        o_rd_req;
    logic [31:0] o_rd_addr;
    logic        i_rd_ack;
    logic [31:0] i_rd_data;
    logic        i_rd_err;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_abort;
`ifdef ZAP_FETCH_PERF_EN
    logic [31:0] o_fetch_cnt;
    logic [31:0] o_discard_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    zap_fetch_sequencer #(
        .WDT      (32),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_halt        (i_halt),
        .i_fifo_full   (i_fifo_full),
        .o_rd_req      (o_rd_req),
        .o_rd_addr     (o_rd_addr),
        .i_rd_ack      (i_rd_ack),
        .i_rd_data     (i_rd_data),
        .i_rd_err      (i_rd_err),
        .o_valid       (o_valid),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_abort       (o_abort)
`ifdef ZAP_FETCH_PERF_EN
        ,
        .o_fetch_cnt   (o_fetch_cnt),
        .o_discard_cnt (o_discard_cnt)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Waits (bounded) for a read request and checks its address.
    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        int n;
        n = 0;
        while (!o_rd_req && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, {31'h0, o_rd_req}, 32'h1);
        chk({tag, "_addr"}, o_rd_addr, exp_addr);
    endtask

    // One complete fetch: request seen, ack after wait_cyc cycles, delivery
    // checked on the following cycle.
    task automatic fetch_one(input string tag, input logic [31:0] exp_addr,
                             input int wait_cyc, input logic err);
        wait_req(tag, exp_addr);
        for (int i = 0; i < wait_cyc; i++) begin
            tick();
            chk({tag, "_hold"}, o_rd_addr, exp_addr);
        end
        i_rd_ack  = 1'b1;
        i_rd_err  = err;
        i_rd_data = data_of(exp_addr);
        tick();
        i_rd_ack  = 1'b0;
        i_rd_err  = 1'b0;
        i_rd_data = 32'hDEAD_BEEF;
        chk({tag, "_valid"}, {31'h0, o_valid}, 32'h1);
        chk({tag, "_pc"}, o_pc, exp_addr);
        chk({tag, "_instr"}, o_instr, err ? 32'h0 : data_of(exp_addr));
        chk({tag, "_abort"}, {31'h0, o_abort}, {31'h0, err});
        chk({tag, "_reqlow"}, {31'h0, o_rd_req}, 32'h0);
    endtask

    initial begin
        i_reset_n     = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        i_halt        = 1'b0;
        i_fifo_full   = 1'b0;
        i_rd_ack      = 1'b0;
        i_rd_data     = 32'h0;
        i_rd_err      = 1'b0;

        tick();
        tick();
        chk("rst_req", {31'h0, o_rd_req}, 32'h0);
        chk("rst_addr", o_rd_addr, 32'h0);
        chk("rst_valid", {31'h0, o_valid}, 32'h0);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_instr", o_instr, 32'h0);
        chk("rst_abort", {31'h0, o_abort}, 32'h0);
        i_reset_n = 1'b1;

        // Zero-wait fetch from RESET_PC, then backpressure.
        fetch_one("f100", 32'h100, 0, 1'b0);
        i_fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("full_noreq", {31'h0, o_rd_req}, 32'h0);
        end
        i_fifo_full = 1'b0;
        tick();
        chk("unfull_req", {31'h0, o_rd_req}, 32'h1);
        chk("unfull_addr", o_rd_addr, 32'h104);
        fetch_one("f104", 32'h104, 0, 1'b0);
        fetch_one("f108", 32'h108, 0, 1'b0);
        // Pulse is one cycle wide.
        tick();
        chk("valid_pulse", {31'h0, o_valid}, 32'h0);

        // Redirect while a slow read to 0x10C is outstanding.
        wait_req("r10c", 32'h10C);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h2000;
        tick();
        i_redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("disc_req", {31'h0, o_rd_req}, 32'h1);
            chk("disc_addr", o_rd_addr, 32'h10C);
            tick();
        end
        chk("disc_addr3", o_rd_addr, 32'h10C);
        i_rd_ack  = 1'b1;
        i_rd_data = 32'h1111_1111;
        tick();
        i_rd_ack = 1'b0;
        chk("disc_novalid", {31'h0, o_valid}, 32'h0);
        chk("disc_reqlow", {31'h0, o_rd_req}, 32'h0);
        tick();
        chk("disc_novalid2", {31'h0, o_valid}, 32'h0);

        // Redirect coinciding with an ack.
        wait_req("r2000", 32'h2000);
        i_rd_ack      = 1'b1;
        i_rd_data     = 32'h2222_2222;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h200;
        tick();
        i_rd_ack   = 1'b0;
        i_redirect = 1'b0;
        chk("coin_novalid", {31'h0, o_valid}, 32'h0);
        chk("coin_reqlow", {31'h0, o_rd_req}, 32'h0);

        // Bus error, then fetching carries on.
        fetch_one("err200", 32'h200, 1, 1'b1);
        fetch_one("f204", 32'h204, 0, 1'b0);

        // Redirect from IDLE to the top of the address space, then wrap.
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFC;
        tick();
        i_redirect = 1'b0;
        chk("redir_noreq", {31'h0, o_rd_req}, 32'h0);
        fetch_one("ftop", 32'hFFFF_FFFC, 0, 1'b0);
        fetch_one("fwrap", 32'h0, 0, 1'b0);

        // Halt blocks new requests.
        i_halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_noreq", {31'h0, o_rd_req}, 32'h0);
        end
        i_halt = 1'b0;
        fetch_one("f4", 32'h4, 0, 1'b0);

`ifdef ZAP_FETCH_PERF_EN
        chk("perf_fetch", o_fetch_cnt, 32'd8);
        chk("perf_discard", o_discard_cnt, 32'd2);
`endif

        // Asynchronous reset in the middle of a request.
        wait_req("r8", 32'h8);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("arst_req", {31'h0, o_rd_req}, 32'h0);
        chk("arst_addr", o_rd_addr, 32'h0);
        chk("arst_valid", {31'h0, o_valid}, 32'h0);
`ifdef ZAP_FETCH_PERF_EN
        chk("arst_fetchcnt", o_fetch_cnt, 32'd0);
`endif
        tick();
        i_reset_n = 1'b1;
        fetch_one("frst", 32'h100, 0, 1'b0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
